pa_bid_loader: RTL
==================

# pa_bid_loader

Upstream/downstream wrapper stage for the four-input priority arbiter. Collects four N-bit bids one at a time over a valid/ready port and presents them as stable, registered inputs to the combinational arbiter. Captures the arbiter's 2-bit winner after one settle cycle and returns winner index and value to the consumer over a second valid/ready port. One round = four bids in, one result out.

## Interface
- N, 8, bid/value width in bits
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- bid_valid  input  1  bid_id/bid_val valid this cycle
- bid_ready  output  1  high only in LOAD
- bid_id  input  2  slot (0..3) the bid targets
- bid_val  input  N  bid value
- arb_in3, arb_in2, arb_in1, arb_in0  output  N  registered slot values driven to the arbiter
- arb_win  input  2  arbiter winner index (combinational from arb_in*)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_idx  output  2  latched winner index
- res_val  output  N  value of winning slot
- round_cnt  output  8  completed rounds, wraps 255->0
- arb_err  output  1  sticky arbiter mismatch flag (see Configuration)

## Operation
- FSM states: LOAD, ARB, HOLD. Reset -> LOAD.
- LOAD: bid_ready=1. Bid accepted when bid_valid&&bid_ready: slot[bid_id] <= bid_val, loaded[bid_id] <= 1. Re-bid to an already loaded slot overwrites value, mask unchanged.
- LOAD -> ARB on the edge where loaded (including the bid being accepted) becomes 4'b1111.
- ARB: bid_ready=0; arb_in* stable; arbiter output settles. At end of ARB: res_idx <= arb_win, res_val <= slot[arb_win], res_valid <= 1 -> HOLD.
- HOLD: res_valid=1, res_idx/res_val stable. On res_valid&&res_ready: res_valid <= 0, loaded <= 0, slots <= 0, round_cnt <= round_cnt+1 (mod 256) -> LOAD.
- Tie resolution belongs to the arbiter (highest index wins); this block never alters arb_win.
- arb_in3..0 are the slot registers directly; they change only on accepted bids or round clear.

## Timing
- Reset values: bid_ready=0 during reset cycle then 1 (state LOAD), arb_in*=0, res_valid=0, res_idx=0, res_val=0, round_cnt=0, arb_err=0, loaded=0.
- Fourth distinct bid accepted at edge k -> ARB during cycle k..k+1, res_valid high after edge k+1.
- Minimum round: 4 bid cycles + 1 ARB + 1 HOLD = 6 cycles; res_ready held high gives result for exactly one cycle.
- res_ready low holds HOLD indefinitely; no bids accepted meanwhile.
- bid_valid with bid_ready=0 is ignored (not queued).
- Reset in any state returns to LOAD next cycle; partial bids and pending result discarded; round_cnt and arb_err cleared.

## Configuration
- PA_LOADER_CHECK_EN defined: in ARB, block computes its own expected winner (max value, highest index on tie) from slot registers; if different from arb_win, arb_err <= 1 (sticky until reset). res_idx still takes arb_win.
- Undefined: checker logic absent, arb_err tied 0.

## Test plan
- Reset, bids slot0=0x10, 1=0x20, 2=0x05, 3=0x7F on consecutive cycles, res_ready=1 -> res_idx=3, res_val=0x7F, res_valid one cycle, round_cnt=1.
- All four bids 0xFF -> res_idx=3, res_val=0xFF (tie goes to slot 3).
- Bids 1=0x40, 1=0x90 (overwrite), 0=0x10, 2=0x20, 3=0x30 -> ARB entered only after fourth distinct slot; res_idx=1, res_val=0x90.
- res_ready held low 10 cycles after result -> res_valid/res_idx/res_val stable, bid_ready=0, bid_valid pulses ignored; then res_ready=1 -> back to LOAD, arb_in* all 0.
- Three bids loaded, reset asserted one cycle -> arb_in*=0, loaded cleared, res_valid=0; following full round produces correct winner.
- With PA_LOADER_CHECK_EN, force arb_win=0 while slot2=0xC0 is max -> arb_err=1 and stays 1 across next round until reset; without macro arb_err=0.

Source files
------------

// File: rtl/pa_bid_loader.sv
// Bid loader for the four-input priority arbiter: collects four slot bids, holds them stable for
// the arbiter, then returns the winner. Optional winner self-check enabled by PA_LOADER_CHECK_EN.
module pa_bid_loader #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [1:0]   bid_id,
    input  logic [N-1:0] bid_val,
    output logic [N-1:0] arb_in3,
    output logic [N-1:0] arb_in2,
    output logic [N-1:0] arb_in1,
    output logic [N-1:0] arb_in0,
    input  logic [1:0]   arb_win,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [1:0]   res_idx,
    output logic [N-1:0] res_val,
    output logic [7:0]   round_cnt,
    output logic         arb_err
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] slot [4];
    logic [3:0]   loaded;
    logic [3:0]   bid_mask;

    assign bid_mask = 4'b0001 << bid_id;

    assign arb_in0 = slot[0];
    assign arb_in1 = slot[1];
    assign arb_in2 = slot[2];
    assign arb_in3 = slot[3];

    // The slot registers feed the arbiter directly, so they only move on accepted bids or round clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            bid_ready <= 1'b1;
            loaded    <= 4'd0;
            res_valid <= 1'b0;
            res_idx   <= 2'd0;
            res_val   <= '0;
            round_cnt <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (bid_valid) begin
                        slot[bid_id] <= bid_val;
                        loaded       <= loaded | bid_mask;
                        if ((loaded | bid_mask) == 4'b1111) begin
                            state     <= ARB;
                            bid_ready <= 1'b0;
                        end
                    end
                end
                ARB: begin
                    res_idx   <= arb_win;
                    res_val   <= slot[arb_win];
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        loaded    <= 4'd0;
                        round_cnt <= round_cnt + 8'd1;
                        bid_ready <= 1'b1;
                        state     <= LOAD;
                        for (int i = 0; i < 4; i++) begin
                            slot[i] <= '0;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    bid_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PA_LOADER_CHECK_EN
    logic [1:0]   exp_win;
    logic [N-1:0] best;

    // Independent winner: largest value, later slots win ties.
    always_comb begin
        exp_win = 2'd0;
        best    = slot[0];
        for (int i = 1; i < 4; i++) begin
            if (slot[i] >= best) begin
                best    = slot[i];
                exp_win = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_err <= 1'b0;
        end else if (state == ARB && exp_win != arb_win) begin
            arb_err <= 1'b1;
        end
    end
`else
    assign arb_err = 1'b0;
`endif

endmodule
